tc_timer: RTL

TC_TIMER -- requirements
Module: tc_timer

---
 rtl/tc_timer_pkg.sv | 43 ++++
 rtl/tc_timer.sv | 115 +++++++++++
 2 files changed

// File: rtl/tc_timer_pkg.sv
// Shared constants for the tc_timer countdown timer: FSM state encodings,
// register word offsets, CTRL bit positions and small CTRL pack helpers.
package tc_timer_pkg;

  // FSM state encodings
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_CNT  = 2'd2;
  localparam logic [1:0] ST_INT  = 2'd3;

  // Register word offsets (byte address bits [3:2])
  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PRESET = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;
  localparam logic [1:0] ADDR_RSVD   = 2'd3;

  // CTRL bit positions
  localparam int CTRL_ENABLE_BIT = 0;
  localparam int CTRL_MODE_LSB   = 1;
  localparam int CTRL_MODE_MSB   = 2;
  localparam int CTRL_IM_BIT     = 3;

  // MODE field values; anything other than RELOAD behaves as one-shot
  localparam logic [1:0] MODE_ONESHOT = 2'd0;
  localparam logic [1:0] MODE_RELOAD  = 2'd1;

  typedef struct packed {
    logic       im;
    logic [1:0] mode;
    logic       enable;
  } ctrl_t;

  // Place the CTRL fields at their bit positions; unused bits read as zero.
  function automatic logic [31:0] ctrl_word(input ctrl_t c);
    logic [31:0] w;
    w = '0;
    w[CTRL_ENABLE_BIT]             = c.enable;
    w[CTRL_MODE_MSB:CTRL_MODE_LSB] = c.mode;
    w[CTRL_IM_BIT]                 = c.im;
    return w;
  endfunction

endpackage

// File: rtl/tc_timer.sv
// tc_timer: memory-mapped countdown timer with CTRL/PRESET/COUNT registers,
// a four-state FSM (IDLE, LOAD, CNT, INT) and a maskable interrupt.
// Optional feature macro: TC_MODE1_EN enables MODE=1 auto-reload. Without
// it the MODE field reads as zero, ignores writes, and every expiry is a
// one-shot expiry.
module tc_timer
  import tc_timer_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        irq
);

  ctrl_t       ctrl;
  logic [31:0] preset;
  logic [31:0] count;
  logic        irq_status;
  logic [1:0]  state;

  logic        ctrl_wr;
  logic        preset_wr;
  logic        count_expiring;
  logic        auto_reload;
  logic [1:0]  mode_in;

  assign ctrl_wr        = we && (addr == ADDR_CTRL);
  assign preset_wr      = we && (addr == ADDR_PRESET);
  assign count_expiring = (count <= 32'd1);

`ifdef TC_MODE1_EN
  assign mode_in     = din[CTRL_MODE_MSB:CTRL_MODE_LSB];
  assign auto_reload = (ctrl.mode == MODE_RELOAD);
`else
  assign mode_in     = MODE_ONESHOT;
  assign auto_reload = 1'b0;
`endif

  // The interrupt line comes only from registered state so it cannot glitch.
  assign irq = ctrl.im & irq_status;

  // Register file and FSM share one block so a bus write to CTRL or PRESET
  // visibly overrides whatever the FSM would have done in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl       <= '0;
      preset     <= '0;
      count      <= '0;
      irq_status <= 1'b0;
      state      <= ST_IDLE;
    end else if (ctrl_wr || preset_wr) begin
      if (ctrl_wr) begin
        ctrl.enable <= din[CTRL_ENABLE_BIT];
        ctrl.mode   <= mode_in;
        ctrl.im     <= din[CTRL_IM_BIT];
      end
      if (preset_wr) begin
        preset <= din;
      end
      irq_status <= 1'b0;
      state      <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (ctrl.enable) begin
            state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          count      <= preset;
          irq_status <= 1'b0;
          state      <= ST_CNT;
        end
        ST_CNT: begin
          if (!ctrl.enable) begin
            state <= ST_IDLE;
          end else if (!count_expiring) begin
            count <= count - 32'd1;
          end else begin
            count      <= '0;
            irq_status <= 1'b1;
            state      <= ST_INT;
          end
        end
        ST_INT: begin
          if (auto_reload) begin
            irq_status <= 1'b0;
          end else begin
            ctrl.enable <= 1'b0;
          end
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Combinational read mux; shows register contents before any pending write.
  always_comb begin
    dout = '0;
    case (addr)
      ADDR_CTRL:   dout = ctrl_word(ctrl);
      ADDR_PRESET: dout = preset;
      ADDR_COUNT:  dout = count;
      ADDR_RSVD:   dout = '0;
      default:     dout = '0;
    endcase
  end

endmodule
